pipe_trace_streamer: RTL and testbench

PIPE_TRACE_STREAMER -- requirements
Module: pipe_trace_streamer

---
 rtl/pipe_trace_pkg.sv | 83 ++++++++
 rtl/trace_fifo.sv | 50 +++++
 rtl/pipe_trace_streamer.sv | 110 +++++++++++
 tb/tb_pipe_trace_streamer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_trace_pkg.sv
// Shared trace definitions: pipeline state sample, trace record, flags layout
// and the helper that serialises a record into its 16-byte frame.
package pipe_trace_pkg;

    localparam logic [7:0]  TRACE_SYNC        = 8'hA5;
    localparam int unsigned TRACE_FRAME_BYTES = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
    } decode_stage_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] debug_branch_target;
        logic        debug_branch_taken;
    } execute_stage_t;

    typedef struct packed {
        logic [1:0] mem_op;
        logic [2:0] wb_op;
    } memwb_stage_t;

    typedef struct packed {
        logic           valid;
        decode_stage_t  decode;
        execute_stage_t execute;
        memwb_stage_t   memwb;
    } pipe_state_t;

    typedef struct packed {
        logic       branch_taken;
        logic [1:0] mem_op;
        logic [2:0] wb_op;
        logic [1:0] rsvd;
    } trace_flags_t;

    typedef struct packed {
        logic [7:0]   seq;
        logic [31:0]  pc;
        logic [31:0]  alu_result;
        logic [31:0]  branch_target;
        trace_flags_t flags;
        logic [4:0]   rd;
    } trace_rec_t;

    function automatic trace_rec_t make_record(input pipe_state_t s, input logic [7:0] seq);
        trace_rec_t r;
        r.seq                = seq;
        r.pc                 = s.decode.pc;
        r.alu_result         = s.execute.alu_result;
        r.branch_target      = s.execute.debug_branch_target;
        r.flags.branch_taken = s.execute.debug_branch_taken;
        r.flags.mem_op       = s.memwb.mem_op;
        r.flags.wb_op        = s.memwb.wb_op;
        r.flags.rsvd         = '0;
        r.rd                 = s.decode.rd;
        return r;
    endfunction

    // Multi-byte words go out least-significant byte first.
    function automatic logic [7:0] frame_byte(input trace_rec_t r, input logic [3:0] idx);
        case (idx)
            4'd0:    return TRACE_SYNC;
            4'd1:    return r.seq;
            4'd2:    return r.pc[7:0];
            4'd3:    return r.pc[15:8];
            4'd4:    return r.pc[23:16];
            4'd5:    return r.pc[31:24];
            4'd6:    return r.alu_result[7:0];
            4'd7:    return r.alu_result[15:8];
            4'd8:    return r.alu_result[23:16];
            4'd9:    return r.alu_result[31:24];
            4'd10:   return r.branch_target[7:0];
            4'd11:   return r.branch_target[15:8];
            4'd12:   return r.branch_target[23:16];
            4'd13:   return r.branch_target[31:24];
            4'd14:   return r.flags;
            default: return {3'b000, r.rd};
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             accepted,
    output logic             full,
    output logic             empty,
    output logic             last
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign last     = (count == (AW+1)'(1));
    assign do_pop   = pop && !empty;
    assign accepted = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accepted) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(accepted) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && accepted) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pipe_trace_streamer.sv
// Streams retired pipeline state as 16-byte trace frames over a byte handshake.
// Define TRACE_DROP_COUNT_EN to expose a saturating 16-bit dropped-event counter.
module pipe_trace_streamer
    import pipe_trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  pipe_state_t in_state,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
`ifdef TRACE_DROP_COUNT_EN
    output logic [15:0] drop_count,
`endif
    output logic        busy
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t     state;
    logic [3:0] idx;
    logic [7:0] seq;
    trace_rec_t head;
    logic       retire;
    logic       handshake;
    logic       frame_done;
    logic       fifo_accept;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_last;

    assign retire     = in_valid && in_state.valid;
    assign handshake  = tx_valid && tx_ready;
    assign frame_done = handshake && (idx == 4'(TRACE_FRAME_BYTES - 1));

    trace_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (retire),
        .push_data (make_record(in_state, seq)),
        .pop       (frame_done),
        .pop_data  (head),
        .accepted  (fifo_accept),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .last      (fifo_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            tx_valid <= 1'b0;
            seq      <= '0;
        end else begin
            if (retire) seq <= seq + 8'd1;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state    <= ST_SEND;
                        tx_valid <= 1'b1;
                        idx      <= '0;
                    end
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (frame_done) begin
                            idx <= '0;
                            // Stay in SEND (no gap) unless the popped frame was the last one
                            // and no new record lands in the same cycle.
                            if (fifo_last && !fifo_accept) begin
                                state    <= ST_IDLE;
                                tx_valid <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data = tx_valid ? frame_byte(head, idx) : 8'h00;
    assign busy    = (state == ST_SEND) || !fifo_empty;

`ifdef TRACE_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (retire && !fifo_accept && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    logic unused_full;
    assign unused_full = fifo_full;
`endif

endmodule

// File: tb/tb_pipe_trace_streamer.sv
// Bench for pipe_trace_streamer: queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed byte expectations.
module tb_pipe_trace_streamer;
    import pipe_trace_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        tx_ready = 1'b0;
    pipe_state_t in_state = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
`ifdef TRACE_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    pipe_trace_streamer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_state   (in_state),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
`ifdef TRACE_DROP_COUNT_EN
        .drop_count (drop_count),
`endif
        .busy       (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of pending frames (128-bit, byte i at [8i+:8]) and a send cursor.
    logic [127:0] m_q[$];
    bit           m_send = 1'b0;
    int           m_pos = 0;
    logic [7:0]   m_seq = 8'h00;
    int           m_drops = 0;
    bit           chk_en = 1'b0;
    bit           m_was_nonempty;
    bit           m_pop;
    logic [7:0]   acc_q[$];

    function automatic logic [127:0] exp_frame(input logic [7:0] s, input pipe_state_t st);
        logic [127:0] f;
        int fl;
        f = '0;
        f[7:0]  = 8'hA5;
        f[15:8] = s;
        for (int i = 0; i < 4; i++) begin
            f[(2+i)*8 +: 8]  = st.decode.pc[i*8 +: 8];
            f[(6+i)*8 +: 8]  = st.execute.alu_result[i*8 +: 8];
            f[(10+i)*8 +: 8] = st.execute.debug_branch_target[i*8 +: 8];
        end
        fl = (st.execute.debug_branch_taken ? 128 : 0) + 32 * int'(st.memwb.mem_op)
             + 4 * int'(st.memwb.wb_op);
        f[119:112] = 8'(fl);
        f[127:120] = 8'(st.decode.rd);
        return f;
    endfunction

    always @(posedge clk) begin
        if (tx_valid && tx_ready) acc_q.push_back(tx_data);
        if (!reset_n) begin
            m_q.delete();
            m_send  = 1'b0;
            m_pos   = 0;
            m_seq   = 8'h00;
            m_drops = 0;
            chk_en  = 1'b1;
        end else begin
            m_was_nonempty = (m_q.size() != 0);
            m_pop = 1'b0;
            if (m_send && tx_ready) begin
                if (m_pos == 15) begin
                    m_pop = 1'b1;
                    m_pos = 0;
                    void'(m_q.pop_front());
                end else begin
                    m_pos++;
                end
            end
            if (in_valid && in_state.valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(exp_frame(m_seq, in_state));
                else if (m_drops < 65535) m_drops++;
                m_seq = m_seq + 8'd1;
            end
            if (m_send) begin
                if (m_pop && m_q.size() == 0) m_send = 1'b0;
            end else begin
                m_send = m_was_nonempty;
            end
        end
    end

    logic [127:0] c_fr;
    logic [7:0]   c_exp;
    always @(negedge clk) begin
        if (chk_en) begin
            c_fr  = (m_q.size() != 0) ? m_q[0] : '0;
            c_exp = m_send ? c_fr[m_pos*8 +: 8] : 8'h00;
            check("tx_valid", 32'(tx_valid), 32'(m_send));
            check("tx_data", 32'(tx_data), 32'(c_exp));
            check("busy", 32'(busy), 32'(m_send || m_q.size() != 0));
`ifdef TRACE_DROP_COUNT_EN
            check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
        end
    end

    function automatic logic [7:0] get_byte(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 8'hxx;
    endfunction

    task automatic send_ev(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] tgt,
                           input logic tk, input logic [1:0] mo, input logic [2:0] wo,
                           input logic [4:0] rd, input logic v);
        in_state.valid                       = v;
        in_state.decode.pc                   = pc;
        in_state.decode.rd                   = rd;
        in_state.execute.alu_result          = alu;
        in_state.execute.debug_branch_target = tgt;
        in_state.execute.debug_branch_taken  = tk;
        in_state.memwb.mem_op                = mo;
        in_state.memwb.wb_op                 = wo;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || m_send || m_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [7:0] exp028 [16];

    initial begin
        exp028 = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE,
                   8'hAD, 8'hDE, 8'h10, 8'h10, 8'h00, 8'h00, 8'hD4, 8'h07};
        @(negedge clk);
        in_valid = 1'b1;
        in_state.valid = 1'b1;
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef TRACE_DROP_COUNT_EN
        check("rst_drop_count", 32'(drop_count), 32'd0);
`endif
        in_valid = 1'b0;
        in_state = '0;
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);

        // Single frame, exact bytes and two-cycle latency
        acc_q.delete();
        send_ev(32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1010, 1'b1, 2'd2, 3'd5, 5'd7, 1'b1);
        check("lat_cycle1_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(tx_valid), 32'd1);
        check("lat_cycle2_sync", 32'(tx_data), 32'hA5);
        wait_idle("single_idle", 64);
        check("single_len", 32'(acc_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) check("single_byte", 32'(get_byte(i)), 32'(exp028[i]));

        // Invalid state sample: no frame, seq unchanged
        send_ev(32'h0000_2000, 32'h1, 32'h2, 1'b0, 2'd1, 3'd1, 5'd1, 1'b0);
        repeat (4) @(negedge clk);
        check("invalid_no_busy", 32'(busy), 32'd0);
        check("invalid_no_frame", 32'(acc_q.size()), 32'd16);
        acc_q.delete();
        send_ev(32'h0000_2000, 32'h1, 32'h2, 1'b0, 2'd1, 3'd1, 5'd1, 1'b1);
        wait_idle("invalid_idle", 64);
        check("invalid_seq", 32'(get_byte(1)), 32'h01);

        // Overflow: six events with a stalled sink
        do_reset();
        tx_ready = 1'b0;
        acc_q.delete();
        for (int i = 0; i < 6; i++)
            send_ev(32'(i * 4), 32'(i), 32'(i + 100), i[0], 2'(i), 3'(i), 5'(i), 1'b1);
        repeat (2) @(negedge clk);
        check("ovf_busy", 32'(busy), 32'd1);
        check("ovf_nothing_sent", 32'(acc_q.size()), 32'd0);
`ifdef TRACE_DROP_COUNT_EN
        check("ovf_drop_count", 32'(drop_count), 32'd2);
`endif
        tx_ready = 1'b1;
        wait_idle("ovf_idle", 200);
        check("ovf_len", 32'(acc_q.size()), 32'd64);
        for (int f = 0; f < 4; f++) check("ovf_seq", 32'(get_byte(f * 16 + 1)), 32'(f));
        acc_q.delete();
        send_ev(32'h40, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 5'd0, 1'b1);
        wait_idle("ovf_next_idle", 64);
        check("ovf_next_seq", 32'(get_byte(1)), 32'h06);

        // Toggling sink over two queued frames
        do_reset();
        tx_ready = 1'b0;
        acc_q.delete();
        send_ev(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 1'b0, 2'd3, 3'd2, 5'd31, 1'b1);
        send_ev(32'h7777_8888, 32'h9999_AAAA, 32'hBBBB_CCCC, 1'b1, 2'd1, 3'd7, 5'd16, 1'b1);
        tx_ready = 1'b1;
        begin
            int n = 0;
            int gaps = 0;
            bit pv;
            bit pr;
            logic [7:0] pd;
            while (busy && n < 200) begin
                pv = tx_valid;
                pr = tx_ready;
                pd = tx_data;
                @(negedge clk);
                n++;
                if (pv && !pr) check("stall_hold", 32'({tx_valid, tx_data}), 32'({1'b1, pd}));
                if (!tx_valid && acc_q.size() > 0 && acc_q.size() < 32) gaps++;
                tx_ready = ~tx_ready;
            end
            check("toggle_budget", 32'(n < 200), 32'd1);
            check("toggle_gaps", 32'(gaps), 32'd0);
        end
        check("toggle_len", 32'(acc_q.size()), 32'd32);
        check("toggle_f2_sync", 32'(get_byte(16)), 32'hA5);
        check("toggle_f2_seq", 32'(get_byte(17)), 32'h01);

        // Reset in the middle of a frame
        do_reset();
        tx_ready = 1'b1;
        acc_q.delete();
        send_ev(32'hCAFE_0000, 32'h1234_5678, 32'h0, 1'b0, 2'd0, 3'd3, 5'd3, 1'b1);
        begin
            int n = 0;
            while (acc_q.size() < 7 && n < 64) begin
                @(negedge clk);
                n++;
            end
            check("midreset_reach", 32'(n < 64), 32'd1);
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_tx_valid", 32'(tx_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        acc_q.delete();
        send_ev(32'hCAFE_0004, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 5'd4, 1'b1);
        wait_idle("midreset_idle", 64);
        check("midreset_len", 32'(acc_q.size()), 32'd16);
        check("midreset_seq", 32'(get_byte(1)), 32'h00);

        // Sequence wrap over 256 events
        do_reset();
        tx_ready = 1'b1;
        acc_q.delete();
        for (int i = 0; i < 256; i++) begin
            send_ev(32'(i), 32'(i * 3), 32'(i + 8), i[1], 2'(i), 3'(i), 5'(i), 1'b1);
            repeat (16) @(negedge clk);
        end
        wait_idle("wrap_idle", 64);
        check("wrap_len", 32'(acc_q.size()), 32'd4096);
        check("wrap_first_seq", 32'(get_byte(1)), 32'h00);
        check("wrap_last_seq", 32'(get_byte(255 * 16 + 1)), 32'hFF);
`ifdef TRACE_DROP_COUNT_EN
        check("wrap_drop_count", 32'(drop_count), 32'd0);
`endif
        acc_q.delete();
        send_ev(32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 5'd0, 1'b1);
        wait_idle("wrap_next_idle", 64);
        check("wrap_next_seq", 32'(get_byte(1)), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
